// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/execute control FSM sharing one memory port; optional SINGLE_STEP_EN adds a step input
module instr_sequencer #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       opcode,
    input  logic             Z,
    input  logic             mem_rdy,
    input  logic             halt_req,
`ifdef SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic             mem_req,
    output logic [1:0]       PS,
    output logic             IL,
    output logic             MB,
    output logic [3:0]       FS,
    output logic             MD,
    output logic             RW,
    output logic             MM,
    output logic             MW,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] retired
);
    localparam int WW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] TO = WW'(TIMEOUT_CYCLES);
    typedef enum logic [2:0] {FETCH, EXEC, MEM, HALT, ERR} state_t;
    state_t state_q, state_d;
    logic [WW-1:0] wait_q, wait_d, wait_inc;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic retire, free, resume, timeout, load;
    assign retired = retired_q;
    assign load = opcode == 4'b1001;
    assign wait_inc = (wait_q == '1) ? wait_q : wait_q + 1'b1;
    assign timeout = (TIMEOUT_CYCLES != 0) && (wait_q == TO) && !mem_rdy;
`ifdef SINGLE_STEP_EN
    logic shot_q, shot_d;
    assign free = step || shot_q;
    assign resume = step;
    // one-instruction permit granted by a step out of HALT, dropped when that instruction retires
    always_comb shot_d = (state_q == HALT && state_d == FETCH) ? 1'b1 : retire ? 1'b0 : shot_q;
    // permit register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) shot_q <= 1'b0;
        else shot_q <= shot_d;
    end
`else
    assign free = 1'b1;
    assign resume = 1'b1;
`endif
    // next state, wait/retire counters and datapath control decode; outputs forced low during reset
    always_comb begin
        state_d = state_q;
        wait_d = wait_q;
        retire = 1'b0;
        mem_req = 1'b0;
        PS = 2'b00;
        IL = 1'b0;
        MB = 1'b0;
        FS = 4'b0000;
        MD = 1'b0;
        RW = 1'b0;
        MM = 1'b0;
        MW = 1'b0;
        halted = 1'b0;
        err = 1'b0;
        case (state_q)
            FETCH: begin
                if (wait_q == '0 && (halt_req || !free)) state_d = HALT;
                else begin
                    mem_req = 1'b1;
                    MM = 1'b1;
                    IL = mem_rdy;
                    state_d = mem_rdy ? EXEC : timeout ? ERR : FETCH;
                    wait_d = mem_rdy ? '0 : wait_inc;
                end
            end
            EXEC: begin
                FS = opcode;
                if (opcode == 4'b1001 || opcode == 4'b1010) state_d = MEM;
                else begin
                    state_d = FETCH;
                    retire = 1'b1;
                    RW = !opcode[3] || opcode == 4'b1000;
                    MB = opcode == 4'b1000;
                    PS = (opcode == 4'b1111) ? 2'b11 :
                         (opcode == 4'b1110) ? 2'b10 :
                         (opcode == 4'b1011) ? (Z ? 2'b10 : 2'b01) :
                         (opcode == 4'b1100) ? (Z ? 2'b01 : 2'b10) : 2'b01;
                end
            end
            MEM: begin
                mem_req = 1'b1;
                FS = opcode;
                MD = load;
                MW = !load;
                RW = load && mem_rdy;
                PS = mem_rdy ? 2'b01 : 2'b00;
                retire = mem_rdy;
                state_d = mem_rdy ? FETCH : timeout ? ERR : MEM;
                wait_d = mem_rdy ? '0 : wait_inc;
            end
            HALT: begin
                halted = 1'b1;
                state_d = (!halt_req && resume) ? FETCH : HALT;
            end
            ERR: err = 1'b1;
            default: state_d = ERR;
        endcase
        retired_d = retired_q + CNT_W'(retire);
        if (!rst_n) {mem_req, PS, IL, MB, FS, MD, RW, MM, MW, halted, err} = '0;
    end
    // state and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            wait_q <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q <= wait_d;
            retired_q <= retired_d;
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: scoreboard bench, randomized instruction stream against an instruction-level model
module tb_instr_sequencer;
    logic clk = 1'b0, rst_n = 1'b0, rst3_n = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic Z = 1'b0, mem_rdy = 1'b0, mem_rdy3 = 1'b0, halt_req = 1'b0;
    logic mem_req, IL, MB, MD, RW, MM, MW, halted, err;
    logic [1:0] PS;
    logic [3:0] FS;
    logic [15:0] retired;
    logic mem_req3, IL3, MB3, MD3, RW3, MM3, MW3, halted3, err3;
    logic [1:0] PS3;
    logic [3:0] FS3;
    logic [3:0] retired3;
    int tests = 0, fails = 0, cnt = 0;
    bit done = 0;
    typedef struct {
        logic [3:0] op;
        logic z;
        int wf, wm;
        logic [1:0] ps;
        logic rw, mb, mem, load;
        int ret;
    } rec_t;
    rec_t q[$];

    instr_sequencer dut (.clk(clk), .rst_n(rst_n), .opcode(opcode), .Z(Z), .mem_rdy(mem_rdy),
        .halt_req(halt_req), .mem_req(mem_req), .PS(PS), .IL(IL), .MB(MB), .FS(FS), .MD(MD),
        .RW(RW), .MM(MM), .MW(MW), .halted(halted), .err(err), .retired(retired));
    instr_sequencer #(.TIMEOUT_CYCLES(3), .CNT_W(4)) dut3 (.clk(clk), .rst_n(rst3_n), .opcode(opcode),
        .Z(Z), .mem_rdy(mem_rdy3), .halt_req(halt_req), .mem_req(mem_req3), .PS(PS3), .IL(IL3),
        .MB(MB3), .FS(FS3), .MD(MD3), .RW(RW3), .MM(MM3), .MW(MW3), .halted(halted3), .err(err3),
        .retired(retired3));

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    function automatic rec_t model(input logic [3:0] op, input logic z, input int wf, input int wm);
        rec_t r;
        r.op = op; r.z = z; r.wf = wf; r.wm = wm;
        r.mem = (op == 4'd9) || (op == 4'd10);
        r.load = op == 4'd9;
        r.rw = op <= 4'd8;
        r.mb = op == 4'd8;
        if (r.mem) r.ps = 2'd0;
        else if (op == 4'd11) r.ps = z ? 2'd2 : 2'd1;
        else if (op == 4'd12) r.ps = z ? 2'd1 : 2'd2;
        else if (op == 4'd14) r.ps = 2'd2;
        else if (op == 4'd15) r.ps = 2'd3;
        else r.ps = 2'd1;
        r.ret = cnt;
        return r;
    endfunction

    task automatic run_instr(input logic [3:0] op, input logic z, input int wf, input int wm, input logic hm);
        rec_t r;
        r = model(op, z, wf, wm);
        cnt++;
        q.push_back(r);
        for (int k = 0; k <= wf; k++) begin
            mem_rdy = (k == wf);
            opcode = 4'($urandom);
            Z = 1'($urandom);
            @(negedge clk);
        end
        opcode = op;
        Z = z;
        mem_rdy = 1'($urandom);
        @(negedge clk);
        if (r.mem) for (int k = 0; k <= wm; k++) begin
            mem_rdy = (k == wm);
            Z = 1'($urandom);
            if (hm) halt_req = 1'b1;
            @(negedge clk);
        end
    endtask

    function automatic int rand_wait();
        return ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
    endfunction

    // monitor: pops one expected instruction per fetch start and follows it cycle by cycle
    initial begin
        rec_t r;
        int idle = 0;
        forever begin
            @(negedge clk); #2;
            if (q.size() == 0) begin
                if (done) break;
                idle++;
                if (idle > 300) begin
                    chk("monitor_idle_timeout", 1, 0);
                    break;
                end
                continue;
            end
            idle = 0;
            r = q.pop_front();
            chk("retired_before", 32'(retired), 32'(r.ret));
            for (int k = 0; k <= r.wf; k++) begin
                if (k > 0) begin @(negedge clk); #2; end
                chk("fetch_req", 32'(mem_req), 1);
                chk("fetch_mm", 32'(MM), 1);
                chk("fetch_il", 32'(IL), 32'(k == r.wf));
                chk("fetch_ctl", {PS, RW, MW, MD, FS}, 0);
            end
            @(negedge clk); #2;
            chk("exec_fs", 32'(FS), 32'(r.op));
            chk("exec_ps", 32'(PS), 32'(r.ps));
            chk("exec_rw", 32'(RW), 32'(r.mem ? 1'b0 : r.rw));
            chk("exec_mb", 32'(MB), 32'(r.mem ? 1'b0 : r.mb));
            chk("exec_other", {mem_req, IL, MD, MW}, 0);
            if (r.mem) for (int k = 0; k <= r.wm; k++) begin
                @(negedge clk); #2;
                chk("mem_req", 32'(mem_req), 1);
                chk("mem_mm", 32'(MM), 0);
                chk("mem_md_mw", {MD, MW}, r.load ? 2 : 1);
                chk("mem_rw", 32'(RW), 32'(r.load && k == r.wm));
                chk("mem_ps", 32'(PS), (k == r.wm) ? 1 : 0);
                chk("mem_fs", 32'(FS), 32'(r.op));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // driver: directed and random stream, halt/reset/timeout/wrap scenarios
    initial begin
        @(negedge clk); #2;
        chk("reset_outputs", {mem_req, PS, IL, MB, FS, MD, RW, MM, MW, halted, err}, 0);
        chk("reset_retired", 32'(retired), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(4'b0010, 1'b0, 0, 0, 1'b0);
        run_instr(4'b1001, 1'b0, 0, 3, 1'b0);
        run_instr(4'b1011, 1'b1, 0, 0, 1'b0);
        run_instr(4'b1011, 1'b0, 1, 0, 1'b0);
        run_instr(4'b1100, 1'b1, 0, 0, 1'b0);
        run_instr(4'b1100, 1'b0, 0, 0, 1'b0);
        run_instr(4'b1111, 1'b0, 0, 0, 1'b0);
        run_instr(4'b1000, 1'b1, 15, 0, 1'b0);
        run_instr(4'b1101, 1'b0, 0, 0, 1'b0);
        run_instr(4'b1110, 1'b1, 2, 0, 1'b0);
        run_instr(4'b1010, 1'b0, 0, 15, 1'b0);
        for (int i = 0; i < 150; i++)
            run_instr(4'($urandom), 1'($urandom), rand_wait(), rand_wait(), 1'b0);
        run_instr(4'b1010, 1'b1, 1, 2, 1'b1);
        #2;
        chk("halt_boundary_req", {mem_req, halted}, 0);
        @(negedge clk); #2;
        chk("halted_1", {halted, mem_req}, 2);
        @(negedge clk); #2;
        chk("halted_2", {halted, mem_req}, 2);
        @(negedge clk);
        halt_req = 1'b0;
        #2;
        chk("halted_release", 32'(halted), 1);
        @(negedge clk);
        run_instr(4'b0101, 1'b0, 0, 0, 1'b0);
        mem_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk); #2;
        chk("stall_req", 32'(mem_req), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_req", {mem_req, IL, MM}, 0);
        chk("async_reset_retired", 32'(retired), 0);
        cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(4'b0111, 1'b0, 0, 0, 1'b0);
        run_instr(4'b1001, 1'b0, 1, 1, 1'b0);
        #2;
        chk("final_retired", 32'(retired), 32'(cnt));
        done = 1;
        rst_n = 1'b0;
        @(negedge clk);
        rst3_n = 1'b1;
        mem_rdy3 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #2;
            chk("to_req", 32'(mem_req3), 32'(k < 4));
            chk("to_err", 32'(err3), 32'(k >= 4));
            @(negedge clk);
        end
        #3 rst3_n = 1'b0;
        #1;
        chk("to_reset", {err3, mem_req3}, 0);
        @(negedge clk);
        rst3_n = 1'b1;
        mem_rdy3 = 1'b1;
        opcode = 4'd0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            @(negedge clk); #2;
            chk("wrap_retired", 32'(retired3), 32'(k % 16));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
